// File: rtl/aes_sha3_host_link_pkg.sv
// Shared types and constants for the AES/SHA3 host link.
// Holds the link FSM state encoding and the byte counts of each transfer phase.
package aes_sha3_host_link_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StWaitIdle,
        StSendSk,
        StWaitBusy,
        StWaitMsg,
        StSendMsg,
        StRxCipher,
        StWaitMac,
        StRxMac,
        StDone
    } state_e;

    localparam int unsigned SALT_KEY_BYTES = 32;
    localparam int unsigned MSG_BYTES      = 16;
    localparam int unsigned CIPHER_BYTES   = 16;
    localparam int unsigned MAC_BYTES      = 32;

    // States in which the link waits on the core and the abort timer runs.
    function automatic logic is_timed_state(state_e s);
        return s inside {StWaitIdle, StWaitBusy, StWaitMsg, StRxCipher, StWaitMac, StRxMac};
    endfunction

endpackage

// File: rtl/host_link_byte_ser.sv
// Loadable parallel-in shift register emitting bytes MSB first.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : load data_i and the number of bytes to emit (len_i)
//   shift_i       : advance to the next byte
//   byte_o        : byte currently at the head of the register
//   last_o        : the head byte is the final byte of the loaded block
module host_link_byte_ser
    import aes_sha3_host_link_pkg::*;
#(
    parameter int unsigned Bytes = SALT_KEY_BYTES,
    parameter int unsigned LenW  = $clog2(Bytes + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [8*Bytes-1:0] data_i,
    input  logic [LenW-1:0]    len_i,
    input  logic               shift_i,
    output logic [7:0]         byte_o,
    output logic               last_o
);

    logic [8*Bytes-1:0] sr_q, sr_d;
    logic [LenW-1:0]    rem_q, rem_d;

    always_comb begin
        sr_d  = sr_q;
        rem_d = rem_q;
        if (load_i) begin
            sr_d  = data_i;
            rem_d = len_i;
        end else if (shift_i && rem_q != '0) begin
            sr_d  = {sr_q[8*Bytes-9:0], 8'h00};
            rem_d = rem_q - LenW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            rem_q <= '0;
        end else begin
            sr_q  <= sr_d;
            rem_q <= rem_d;
        end
    end

    assign byte_o = sr_q[8*Bytes-1 -: 8];
    assign last_o = (rem_q == LenW'(1));

endmodule

// File: rtl/aes_sha3_host_link.sv
// Host-side link to the byte-serial AES/SHA3 core.
// Takes one job (salt||key, message, mode), streams salt||key then the message to the core
// as contiguous dev_start bursts, then collects 16 cipher bytes and 32 MAC bytes.
// Ports:
//   cmd_*  : job request handshake and payload (latched on accept)
//   dev_*  : registered core input pins / core output pins
//   rsp_*  : one-cycle completion pulse, error flag (timeout) and collected results
module aes_sha3_host_link
    import aes_sha3_host_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 8192,
    parameter int unsigned TO_W           = 14
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_mode_i,
    input  logic [255:0] cmd_salt_key_i,
    input  logic [127:0] cmd_msg_i,
    output logic         dev_start_o,
    output logic [7:0]   dev_data_o,
    output logic         dev_mode_o,
    input  logic [7:0]   dev_data_in_i,
    input  logic         dev_valid_i,
    input  logic         dev_ien_i,
    output logic         rsp_valid_o,
    output logic         rsp_err_o,
    output logic [127:0] rsp_cipher_o,
    output logic [255:0] rsp_mac_o
);

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            seen_low_q, seen_low_d;
    logic [127:0]    msg_q, msg_d;
    logic            mode_q, mode_d;
    logic [127:0]    cipher_q, cipher_d;
    logic [255:0]    mac_q, mac_d;
    logic            start_q, start_d;
    logic [7:0]      data_q, data_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic            capture;

    logic            ser_load, ser_shift, ser_last;
    logic [255:0]    ser_data;
    logic [5:0]      ser_len;
    logic [7:0]      ser_byte;

    // Salt||key is loaded on accept; the message reloads it once the core is ready again.
    host_link_byte_ser #(
        .Bytes(SALT_KEY_BYTES),
        .LenW (6)
    ) u_ser (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (ser_load),
        .data_i (ser_data),
        .len_i  (ser_len),
        .shift_i(ser_shift),
        .byte_o (ser_byte),
        .last_o (ser_last)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        seen_low_d  = seen_low_q;
        msg_d       = msg_q;
        mode_d      = mode_q;
        cipher_d    = cipher_q;
        mac_d       = mac_q;
        start_d     = 1'b0;
        data_d      = 8'h00;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        capture     = 1'b0;
        ser_load    = 1'b0;
        ser_shift   = 1'b0;
        ser_data    = '0;
        ser_len     = '0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    msg_d    = cmd_msg_i;
                    mode_d   = cmd_mode_i;
                    cipher_d = '0;
                    mac_d    = '0;
                    cnt_d    = '0;
                    ser_load = 1'b1;
                    ser_data = cmd_salt_key_i;
                    ser_len  = 6'(SALT_KEY_BYTES);
                    state_d  = StWaitIdle;
                end
            end
            StWaitIdle: if (!dev_ien_i) state_d = StSendSk;
            StSendSk: begin
                start_d   = 1'b1;
                data_d    = ser_byte;
                ser_shift = 1'b1;
                if (ser_last) state_d = StWaitBusy;
            end
            StWaitBusy: if (dev_ien_i) state_d = StWaitMsg;
            StWaitMsg: begin
                if (!dev_ien_i) begin
                    ser_load = 1'b1;
                    ser_data = {msg_q, 128'h0};
                    ser_len  = 6'(MSG_BYTES);
                    state_d  = StSendMsg;
                end
            end
            StSendMsg: begin
                start_d   = 1'b1;
                data_d    = ser_byte;
                ser_shift = 1'b1;
                if (ser_last) begin
                    cnt_d   = '0;
                    state_d = StRxCipher;
                end
            end
            StRxCipher: begin
                if (dev_valid_i) begin
                    cipher_d[{cnt_q[3:0], 3'b000} +: 8] = dev_data_in_i;
                    capture = 1'b1;
                    if (cnt_q == 5'(CIPHER_BYTES - 1)) begin
                        cnt_d      = '0;
                        seen_low_d = 1'b0;
                        state_d    = StWaitMac;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StWaitMac: begin
                // The MAC burst must be a fresh rising edge, not a continuation of the cipher.
                if (!dev_valid_i) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    mac_d[7:0] = dev_data_in_i;
                    capture    = 1'b1;
                    cnt_d      = 5'd1;
                    state_d    = StRxMac;
                end
            end
            StRxMac: begin
                if (dev_valid_i) begin
                    mac_d[{cnt_q, 3'b000} +: 8] = dev_data_in_i;
                    capture = 1'b1;
                    if (cnt_q == 5'(MAC_BYTES - 1)) begin
                        cnt_d       = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StDone: begin
                mode_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort timer: restarts on any progress, fires after TIMEOUT_CYCLES idle cycles.
        if (state_d != state_q || capture) begin
            to_d = '0;
        end else if (is_timed_state(state_q)) begin
            if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                to_d        = '0;
                mode_d      = 1'b0;
                start_d     = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = StIdle;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            to_q        <= '0;
            seen_low_q  <= 1'b0;
            msg_q       <= '0;
            mode_q      <= 1'b0;
            cipher_q    <= '0;
            mac_q       <= '0;
            start_q     <= 1'b0;
            data_q      <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            seen_low_q  <= seen_low_d;
            msg_q       <= msg_d;
            mode_q      <= mode_d;
            cipher_q    <= cipher_d;
            mac_q       <= mac_d;
            start_q     <= start_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign dev_start_o  = start_q;
    assign dev_data_o   = data_q;
    assign dev_mode_o   = mode_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_cipher_o = cipher_q;
    assign rsp_mac_o    = mac_q;

endmodule
